id_pipe: RTL and testbench
==========================

// Module: id_pipe
// PURPOSE
//  Registered, parametrised instruction-decode stage for the SCC core. Accepts 32-bit instructions from IF
//  over a valid/ready handshake and emits one registered micro-op bundle (fields + control flags) to EX.
//  Owns the multi-cycle MUL interlock and the halt state internally, replacing the external catch/prevent signals.
// PARAMETERS
//  REG_W       4   register-index width; fields are dst=[21+REG_W-1:21], op1=[17+REG_W-1:17], op2=[13+REG_W-1:13]
//  IMM_W       16  immediate width, taken from instr[IMM_W-1:0], zero-extended to 16 on imm_o (IMM_W<=16)
//  MUL_CYCLES  4   total MUL occupancy in cycles (>=2); decoder stalls MUL_CYCLES-1 cycles after issuing a MUL
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  in_valid     in   1       instr valid from IF
//  in_ready     out  1       decoder can accept instr this cycle
//  instr        in   32      instruction word
//  out_valid    out  1       micro-op valid to EX
//  out_ready    in   1       EX accepts micro-op
//  flush        in   1       drop held micro-op (branch taken)
//  resume       in   1       leave HALTED
//  dst_o/op1_o/op2_o out REG_W  register indices; b_cond_o out 4 = instr[24:21]
//  imm_o        out  16      immediate
//  alu_op_o     out  3       instr[27:25]
//  flags_o      out  12      {alu,set_nzcv,shift,imm,load,store,branch,wr_reg,clr,set,sav_nzcv,br_reg}
//  mov_o        out  2       0 none,1 mov,2 movt,3 movf
//  halt_o       out  1       high while in HALTED
//  illegal_o    out  1       held micro-op is an undefined encoding (decoded as NOP)
// BEHAVIOUR
//  Reset: all outputs 0, state RUN, MUL counter 0. Outputs are registered; no combinational instr->output path.
//  in_ready = (state==RUN) && (!out_valid || out_ready). Transfer in = in_valid&&in_ready; out = out_valid&&out_ready.
//  Latency 1: on transfer in, bundle decoded and registered, out_valid=1 next cycle; bundle held stable until transfer out.
//  Transfer out without transfer in: out_valid->0. Simultaneous in+out: new bundle replaces old, out_valid stays 1.
//  Decode (instr[31:30]): 0 = imm class: bit29=1 ALU, bit29=0 special (op 0 mov,1 movt,2 clr,3 set,4/5 shift,
//   6 movf -> sav_nzcv with wr_reg=0 if bit28 else mov=3, 7 illegal); wr_reg=1, imm=1, set_nzcv=bit28.
//   1 = reg ALU, wr_reg=1, set_nzcv=bit28. 2 = mem: bit25=0 load (wr_reg=1), bit25=1 store (wr_reg=0), imm=1.
//   3 = system: bit28 HALT; else bit27=1 NOP; else op[26:25] 0/1 branch, 2 branch-reg (br_reg=1,imm=1), 3 illegal.
//  MUL = ALU class with alu_op==0: set_nzcv forced 0.
//  FSM: RUN -> MUL_WAIT on accepting a MUL, counter loaded MUL_CYCLES-1; decrements each cycle; at 1 -> RUN
//   (in_ready high again the cycle counter reaches 0). MUL_WAIT ignores flush.
//   RUN -> HALTED on accepting HALT; halt uop issued normally (wr_reg=0); halt_o=1 from next cycle.
//   HALTED -> RUN on resume (in_ready high next cycle); resume in RUN/MUL_WAIT ignored.
//  flush: out_valid->0 next cycle; any same-cycle transfer-in is discarded; does not change state or counter;
//   a flushed HALT still enters HALTED.
//  Reset mid-MUL_WAIT or mid-HALTED: immediate return to RUN, out_valid=0.
//  No back-to-back MULs possible; EX never sees a second MUL inside MUL_CYCLES.
// TESTING
//  T1 instr=0x2600_0005 (imm ALU op3) with out_ready=1 -> next cycle out_valid=1, alu=1, alu_op=3, imm=1, imm_o=0x0005.
//  T2 instr=0x3000_0000 (MUL, bit28=1) -> set_nzcv=0, in_ready low exactly 3 cycles (MUL_CYCLES=4), then high.
//  T3 out_ready=0 for 5 cycles with valid input -> bundle stable, in_ready=0, no instr lost; release -> in-order delivery.
//  T4 instr=0xD000_0000 (HALT) -> halt_o=1, in_ready=0 for 20 cycles; resume pulse -> in_ready=1 next cycle, halt_o=0.
//  T5 flush asserted together with valid branch 0xC000_0010 -> no micro-op emitted, next instr decoded normally.
//  T6 rst_n low during MUL_WAIT -> all outputs 0 asynchronously; after release in_ready=1 first cycle; instr 0xC600_0000 -> illegal_o=1.

Source files
------------

// File: rtl/id_pipe_if.sv
// IF->ID->EX handshake and micro-op bundle between the decode stage and its neighbours.
// master = IF/EX side, slave = decoder.
interface id_pipe_if #(parameter int REG_W = 4);
  logic             in_valid, in_ready;
  logic [31:0]      instr;
  logic             out_valid, out_ready;
  logic             flush, resume;
  logic [REG_W-1:0] dst_o, op1_o, op2_o;
  logic [3:0]       b_cond_o;
  logic [15:0]      imm_o;
  logic [2:0]       alu_op_o;
  logic [11:0]      flags_o;
  logic [1:0]       mov_o;
  logic             halt_o, illegal_o;

  modport master (
    output in_valid, instr, out_ready, flush, resume,
    input  in_ready, out_valid, dst_o, op1_o, op2_o, b_cond_o, imm_o,
           alu_op_o, flags_o, mov_o, halt_o, illegal_o
  );
  modport slave (
    input  in_valid, instr, out_ready, flush, resume,
    output in_ready, out_valid, dst_o, op1_o, op2_o, b_cond_o, imm_o,
           alu_op_o, flags_o, mov_o, halt_o, illegal_o
  );
endinterface

// File: rtl/id_pipe.sv
// Registered instruction-decode stage: one-deep micro-op register with valid/ready,
// internal MUL interlock and HALT state.
module id_pipe #(
  parameter int REG_W      = 4,
  parameter int IMM_W      = 16,
  parameter int MUL_CYCLES = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  id_pipe_if.slave bus
);
  localparam int CNT_W = $clog2(MUL_CYCLES);

  typedef enum logic [1:0] {RUN, MUL_WAIT, HALTED} state_e;

  typedef struct packed {
    logic alu, set_nzcv, shift, imm, load, store, branch, wr_reg, clr, set, sav_nzcv, br_reg;
  } flags_t;

  typedef struct packed {
    logic [REG_W-1:0] dst, op1, op2;
    logic [3:0]       b_cond;
    logic [15:0]      imm;
    logic [2:0]       alu_op;
    flags_t           flags;
    logic [1:0]       mov;
    logic             illegal;
  } uop_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  uop_t             uop_q, uop_d, dec;
  logic             is_mul, is_halt, xfer_in, xfer_out;
  logic [1:0]       cls;
  logic [2:0]       op;

  // rst_n gates in_ready so every output reads 0 while reset is held
  assign bus.in_ready = rst_n && (state_q == RUN) && (!out_valid_q || bus.out_ready);
  assign xfer_in      = bus.in_valid && bus.in_ready;
  assign xfer_out     = out_valid_q && bus.out_ready;

  always_comb begin
    cls         = bus.instr[31:30];
    op          = bus.instr[27:25];
    dec         = '0;
    is_mul      = 1'b0;
    is_halt     = 1'b0;
    dec.dst     = bus.instr[21 +: REG_W];
    dec.op1     = bus.instr[17 +: REG_W];
    dec.op2     = bus.instr[13 +: REG_W];
    dec.b_cond  = bus.instr[24:21];
    dec.imm     = 16'(bus.instr[IMM_W-1:0]);
    dec.alu_op  = op;
    case (cls)
      2'd0: begin
        dec.flags.wr_reg   = 1'b1;
        dec.flags.imm      = 1'b1;
        dec.flags.set_nzcv = bus.instr[28];
        if (bus.instr[29]) begin
          dec.flags.alu = 1'b1;
          is_mul        = (op == 3'd0);
        end else begin
          case (op)
            3'd0:       dec.mov = 2'd1;
            3'd1:       dec.mov = 2'd2;
            3'd2:       dec.flags.clr = 1'b1;
            3'd3:       dec.flags.set = 1'b1;
            3'd4, 3'd5: dec.flags.shift = 1'b1;
            3'd6: begin
              if (bus.instr[28]) begin
                dec.flags.sav_nzcv = 1'b1;
                dec.flags.wr_reg   = 1'b0;
              end else begin
                dec.mov = 2'd3;
              end
            end
            default: begin
              dec.flags   = '0;
              dec.illegal = 1'b1;
            end
          endcase
        end
      end
      2'd1: begin
        dec.flags.alu      = 1'b1;
        dec.flags.wr_reg   = 1'b1;
        dec.flags.set_nzcv = bus.instr[28];
        is_mul             = (op == 3'd0);
      end
      2'd2: begin
        dec.flags.imm    = 1'b1;
        dec.flags.load   = !bus.instr[25];
        dec.flags.store  = bus.instr[25];
        dec.flags.wr_reg = !bus.instr[25];
      end
      default: begin
        if (bus.instr[28]) begin
          is_halt = 1'b1;
        end else if (!bus.instr[27]) begin
          case (bus.instr[26:25])
            2'd0, 2'd1: dec.flags.branch = 1'b1;
            2'd2: begin
              dec.flags.branch = 1'b1;
              dec.flags.br_reg = 1'b1;
              dec.flags.imm    = 1'b1;
            end
            default: dec.illegal = 1'b1;
          endcase
        end
      end
    endcase
    if (is_mul) dec.flags.set_nzcv = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    uop_d       = uop_q;
    case (state_q)
      RUN: begin
        if (xfer_in && is_mul) begin
          state_d = MUL_WAIT;
          cnt_d   = CNT_W'(MUL_CYCLES - 1);
        end else if (xfer_in && is_halt) begin
          state_d = HALTED;
        end
      end
      MUL_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RUN;
      end
      HALTED:  if (bus.resume) state_d = RUN;
      default: state_d = RUN;
    endcase
    // flush drops the bundle but the FSM above still sees the accepted instr
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (xfer_in) begin
      out_valid_d = 1'b1;
      uop_d       = dec;
    end else if (xfer_out) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      uop_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      uop_q       <= uop_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dst_o     = uop_q.dst;
  assign bus.op1_o     = uop_q.op1;
  assign bus.op2_o     = uop_q.op2;
  assign bus.b_cond_o  = uop_q.b_cond;
  assign bus.imm_o     = uop_q.imm;
  assign bus.alu_op_o  = uop_q.alu_op;
  assign bus.flags_o   = uop_q.flags;
  assign bus.mov_o     = uop_q.mov;
  assign bus.illegal_o = uop_q.illegal;
  assign bus.halt_o    = (state_q == HALTED);
endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe: decode vectors, MUL interlock, backpressure, halt, flush, reset.
module tb_id_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_pipe_if #(.REG_W(4)) bus();
  id_pipe #(.REG_W(4), .IMM_W(16), .MUL_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // flags: {alu,set_nzcv,shift,imm,load,store,branch,wr_reg,clr,set,sav_nzcv,br_reg}
  localparam int NV = 10;
  logic [31:0] v_instr [NV] = '{32'h80A0_0000, 32'h8200_0000, 32'h0C00_0000, 32'h1C00_0000,
                                32'h5A00_0000, 32'hC400_0000, 32'h0400_0000, 32'h0200_0000,
                                32'h0800_0000, 32'h0E00_0000};
  logic [11:0] v_flags [NV] = '{12'h190, 12'h140, 12'h110, 12'h502,
                                12'hC10, 12'h121, 12'h118, 12'h110,
                                12'h310, 12'h000};
  logic [1:0]  v_mov   [NV] = '{2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0};
  logic [3:0]  v_dst   [NV] = '{4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
  logic        v_ill   [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;
    bus.resume    = 1'b0;
    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready",  32'(bus.in_ready), 0);
    chk("rst_halt",      32'(bus.halt_o), 0);
    chk("rst_flags",     32'(bus.flags_o), 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);

    // T1: imm ALU op3
    bus.in_valid = 1'b1;
    bus.instr    = 32'h2600_0005;
    step();
    bus.in_valid = 1'b0;
    chk("t1_valid",  32'(bus.out_valid), 1);
    chk("t1_flags",  32'(bus.flags_o), 32'h910);
    chk("t1_alu_op", 32'(bus.alu_op_o), 3);
    chk("t1_imm",    32'(bus.imm_o), 32'h0005);
    step();
    chk("t1_drain",  32'(bus.out_valid), 0);

    // T2: MUL interlock, following instr held valid during the wait
    bus.in_valid = 1'b1;
    bus.instr    = 32'h3000_0000;
    step();
    bus.instr = 32'h2600_0007;
    chk("t2_valid", 32'(bus.out_valid), 1);
    chk("t2_flags", 32'(bus.flags_o), 32'h910);
    chk("t2_rdy_c1", 32'(bus.in_ready), 0);
    step();
    chk("t2_rdy_c2", 32'(bus.in_ready), 0);
    chk("t2_nov_c2", 32'(bus.out_valid), 0);
    step();
    chk("t2_rdy_c3", 32'(bus.in_ready), 0);
    step();
    chk("t2_rdy_c4", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    chk("t2_next_valid", 32'(bus.out_valid), 1);
    chk("t2_next_imm",   32'(bus.imm_o), 32'h0007);
    step();

    // T3: backpressure
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h2600_0011;
    step();
    bus.instr = 32'h2600_0022;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_imm",   32'(bus.imm_o), 32'h0011);
      chk("t3_hold_valid", 32'(bus.out_valid), 1);
      chk("t3_hold_rdy",   32'(bus.in_ready), 0);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t3_rel_rdy", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    chk("t3_second_valid", 32'(bus.out_valid), 1);
    chk("t3_second_imm",   32'(bus.imm_o), 32'h0022);
    step();
    chk("t3_drain", 32'(bus.out_valid), 0);

    // decode table, back-to-back issue
    bus.in_valid = 1'b1;
    for (int i = 0; i < NV; i++) begin
      bus.instr = v_instr[i];
      step();
      chk("tab_flags", 32'(bus.flags_o), 32'(v_flags[i]));
      chk("tab_mov",   32'(bus.mov_o), 32'(v_mov[i]));
      chk("tab_dst",   32'(bus.dst_o), 32'(v_dst[i]));
      chk("tab_ill",   32'(bus.illegal_o), 32'(v_ill[i]));
    end
    bus.in_valid = 1'b0;
    step();

    // T4: halt
    bus.in_valid = 1'b1;
    bus.instr    = 32'hD000_0000;
    step();
    bus.in_valid = 1'b0;
    chk("t4_valid", 32'(bus.out_valid), 1);
    chk("t4_flags", 32'(bus.flags_o), 0);
    for (int i = 0; i < 20; i++) begin
      chk("t4_halt", 32'(bus.halt_o), 1);
      chk("t4_rdy",  32'(bus.in_ready), 0);
      step();
    end
    bus.resume = 1'b1;
    step();
    bus.resume = 1'b0;
    chk("t4_unhalt", 32'(bus.halt_o), 0);
    chk("t4_rdy_back", 32'(bus.in_ready), 1);

    // T5: flush with branch, then normal decode
    bus.in_valid = 1'b1;
    bus.instr    = 32'hC000_0010;
    bus.flush    = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("t5_flushed", 32'(bus.out_valid), 0);
    step();
    chk("t5_br_valid", 32'(bus.out_valid), 1);
    chk("t5_br_flags", 32'(bus.flags_o), 32'h020);
    chk("t5_br_imm",   32'(bus.imm_o), 32'h0010);
    bus.instr = 32'h2600_0003;
    step();
    bus.in_valid = 1'b0;
    chk("t5_next_imm", 32'(bus.imm_o), 32'h0003);
    step();

    // T6: reset during MUL_WAIT
    bus.in_valid = 1'b1;
    bus.instr    = 32'h3000_0000;
    step();
    bus.in_valid = 1'b0;
    chk("t6_mul_rdy", 32'(bus.in_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.out_valid), 0);
    chk("t6_rst_flags", 32'(bus.flags_o), 0);
    chk("t6_rst_imm",   32'(bus.imm_o), 0);
    chk("t6_rst_rdy",   32'(bus.in_ready), 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("t6_rdy_first", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.instr    = 32'hC600_0000;
    step();
    bus.in_valid = 1'b0;
    chk("t6_ill_valid", 32'(bus.out_valid), 1);
    chk("t6_illegal",   32'(bus.illegal_o), 1);
    chk("t6_ill_flags", 32'(bus.flags_o), 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
